// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - eight-channel LED PWM with shadow duty registers applied atomically at period wrap
module pwm_bank #(
   parameter int PRESC_LEN = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       commit,
   output logic [7:0] led,
   output logic       frame_start,
   output logic       commit_pending
);

   logic [PRESC_LEN-1:0] presc;
   logic [7:0]           pwm_ctr;
   logic [7:0]           shadow [8];
   logic [7:0]           active [8];
   logic                 pending;
   logic                 tick;
   logic                 wrap;
   logic                 apply;

   assign tick  = &presc;
   assign wrap  = tick && (pwm_ctr == 8'hFF);
   // A commit arriving in the wrap cycle itself is honoured at that wrap.
   assign apply = wrap && (pending || commit);

   assign commit_pending = pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         presc       <= '0;
         pwm_ctr     <= '0;
         pending     <= 1'b0;
         frame_start <= 1'b0;
         led         <= '0;
         for (int i = 0; i < 8; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         presc       <= presc + 1'b1;
         frame_start <= wrap;
         pending     <= wrap ? 1'b0 : (pending | commit);
         if (tick)
            pwm_ctr <= pwm_ctr + 8'd1;
         if (wr_en)
            shadow[wr_addr] <= wr_data;
         // Shadow is read before this cycle's write lands, so a same-cycle write is not applied.
         if (apply)
            for (int i = 0; i < 8; i++)
               active[i] <= shadow[i];
         for (int i = 0; i < 8; i++)
            led[i] <= (pwm_ctr < active[i]);
      end
   end

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - directed self-checking bench for pwm_bank with a 1024-clock period
module tb_pwm_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic       commit;
   logic [7:0] led;
   logic       frame_start;
   logic       commit_pending;

   int n_checks = 0;
   int n_errors = 0;
   int hi_cnt [8];
   int n;

   pwm_bank #(.PRESC_LEN(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .commit         (commit),
      .led            (led),
      .frame_start    (frame_start),
      .commit_pending (commit_pending)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_ch(input logic [2:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      step();
      commit = 1'b0;
   endtask

   // Returns the number of edges until frame_start is seen; bounded so a dead DUT cannot hang the run.
   task automatic wait_frame(output int cnt);
      cnt = 0;
      for (int k = 0; k < 1100; k++) begin
         step();
         cnt++;
         if (frame_start) return;
      end
      check_eq("frame_start_timeout", 0, 1);
   endtask

   task automatic measure();
      for (int i = 0; i < 8; i++) hi_cnt[i] = 0;
      repeat (1024) begin
         step();
         for (int i = 0; i < 8; i++)
            if (led[i]) hi_cnt[i]++;
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;

      // Reset and free-running period
      repeat (3) step();
      rst = 1'b0;
      check_eq("rst_led", int'(led), 0);
      check_eq("rst_pending", int'(commit_pending), 0);
      check_eq("rst_frame", int'(frame_start), 0);
      wait_frame(n);
      check_eq("first_frame_dist", n, 1024);
      wait_frame(n);
      check_eq("second_frame_dist", n, 1024);

      // Duty sweep
      write_ch(3'd0, 8'd0);
      write_ch(3'd1, 8'd1);
      write_ch(3'd2, 8'd128);
      write_ch(3'd3, 8'd255);
      do_commit();
      check_eq("sweep_pending_set", int'(commit_pending), 1);
      wait_frame(n);
      check_eq("sweep_pending_clr", int'(commit_pending), 0);
      measure();
      check_eq("sweep_ch0", hi_cnt[0], 0);
      check_eq("sweep_ch1", hi_cnt[1], 4);
      check_eq("sweep_ch2", hi_cnt[2], 512);
      check_eq("sweep_ch3", hi_cnt[3], 1020);
      check_eq("sweep_ch4", hi_cnt[4], 0);

      // Atomic update: uncommitted writes leave outputs alone
      repeat (100) step();
      for (int c = 0; c < 8; c++) write_ch(c[2:0], 8'hFF);
      wait_frame(n);
      measure();
      check_eq("atomic_hold_ch1", hi_cnt[1], 4);
      check_eq("atomic_hold_ch2", hi_cnt[2], 512);
      check_eq("atomic_hold_ch5", hi_cnt[5], 0);
      repeat (50) step();
      do_commit();
      check_eq("atomic_pending", int'(commit_pending), 1);
      repeat (900) step();
      check_eq("atomic_pending_hold", int'(commit_pending), 1);
      wait_frame(n);
      check_eq("atomic_pending_clr", int'(commit_pending), 0);
      check_eq("atomic_led_at_wrap", int'(led), 8'h00);
      step();
      check_eq("atomic_led_all_on", int'(led), 8'hFF);

      // Commit and write in the wrap cycle
      write_ch(3'd5, 8'h10);
      repeat (1021) step();
      commit  = 1'b1;
      wr_en   = 1'b1;
      wr_addr = 3'd5;
      wr_data = 8'h40;
      step();
      commit  = 1'b0;
      wr_en   = 1'b0;
      check_eq("simul_frame", int'(frame_start), 1);
      check_eq("simul_pending", int'(commit_pending), 0);
      measure();
      check_eq("simul_ch5_old", hi_cnt[5], 64);
      check_eq("simul_ch0", hi_cnt[0], 1020);
      do_commit();
      check_eq("simul_pending2", int'(commit_pending), 1);
      wait_frame(n);
      measure();
      check_eq("simul_ch5_new", hi_cnt[5], 256);

      // Reset mid-operation
      write_ch(3'd2, 8'd200);
      do_commit();
      wait_frame(n);
      repeat (300) step();
      do_commit();
      check_eq("midrst_pending_before", int'(commit_pending), 1);
      check_eq("midrst_led2_before", int'(led[2]), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("midrst_led", int'(led), 0);
      check_eq("midrst_pending", int'(commit_pending), 0);
      check_eq("midrst_frame", int'(frame_start), 0);
      do_commit();
      wait_frame(n);
      check_eq("midrst_frame_dist", n, 1023);
      measure();
      check_eq("midrst_ch2", hi_cnt[2], 0);
      check_eq("midrst_ch5", hi_cnt[5], 0);

      // Last write wins
      write_ch(3'd7, 8'h20);
      write_ch(3'd7, 8'h90);
      do_commit();
      wait_frame(n);
      measure();
      check_eq("lastwr_ch7", hi_cnt[7], 576);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
